// File: rtl/data_island_packet_serializer.sv
// rtl/data_island_packet_serializer.sv - data-island packet serializer with BCH(64,56)/(32,24) ECC
// Emits header bit and two bits of each subpacket per pixel clock; ECC bytes fill the tail cycles.
module data_island_packet_serializer (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [8:0]       packet_data,
  output logic [4:0]       packet_counter,
  output logic             packet_done
);

  logic [4:0]      r_cnt;
  logic [7:0]      r_hdr_ecc;
  logic [3:0][7:0] r_sub_ecc;
  logic            r_done;

  logic            w_first;
  logic            w_hdr_phase;
  logic            w_sub_phase;
  logic            w_hdr_in;
  logic            w_hdr_bit;
  logic [7:0]      w_hdr_next;
  logic [3:0][1:0] w_sub_bits;
  logic [3:0][7:0] w_sub_next;

  // One LSB-first step of the G(x) = 1 + x^6 + x^7 + x^8 divider.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
    logic fb;
    fb = d ^ ecc[0];
    return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
  endfunction

  assign w_first     = (r_cnt == 5'd0);
  assign w_hdr_phase = (r_cnt < 5'd24);
  assign w_sub_phase = (r_cnt < 5'd28);

  // Counter 0 seeds from zero so a stale or aborted packet never leaks into the next ECC.
  assign w_hdr_in   = header[r_cnt];
  assign w_hdr_next = bch_step(w_first ? 8'h00 : r_hdr_ecc, w_hdr_in);
  assign w_hdr_bit  = w_hdr_phase ? w_hdr_in : r_hdr_ecc[r_cnt[2:0]];

  for (genvar i = 0; i < 4; i++) begin : g_sub
    logic [1:0] w_pair;
    logic [7:0] w_half;
    assign w_pair        = sub[i][{r_cnt, 1'b0} +: 2];
    assign w_half        = bch_step(w_first ? 8'h00 : r_sub_ecc[i], w_pair[0]);
    assign w_sub_next[i] = bch_step(w_half, w_pair[1]);
    assign w_sub_bits[i] = w_sub_phase ? w_pair : r_sub_ecc[i][{r_cnt[1:0], 1'b0} +: 2];
  end

  always_comb begin
    packet_data = 9'd0;
    if (data_island_period) begin
      packet_data = {w_sub_bits, w_hdr_bit};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= 5'd0;
      r_hdr_ecc <= 8'h00;
      r_sub_ecc <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= data_island_period && (r_cnt == 5'd31);
      if (data_island_period) begin
        r_cnt <= r_cnt + 5'd1;
        if (w_hdr_phase) r_hdr_ecc <= w_hdr_next;
        if (w_sub_phase) r_sub_ecc <= w_sub_next;
      end else begin
        r_cnt <= 5'd0;
      end
    end
  end

  assign packet_counter = r_cnt;
  assign packet_done    = r_done;

endmodule
